uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO. It is the successor to the fixed 8N1 transmit path in `uart`. It accepts words on a one-cycle `send` strobe and buffers them. It serialises them onto `tx` with configurable data width, baud divisor, parity and stop bits. It sits between the processor's I/O write path and the FPGA TX pin, clocked by the 100 MHz board clock.

---
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO in front of it.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 10416,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk_100,
  input  logic                 clr_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  input  logic                 ovf_clr,
  output logic                 tx,
  output logic                 busy,
  output logic                 led_tx,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 overflow
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int BW    = $clog2(CLK_DIV);
  localparam logic [BW-1:0]    BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_MAX  = 4'(DATA_BITS - 1);
  localparam logic             STOP_MAX = 1'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr, r_rptr;
  logic [FIFO_AW:0]     r_count;
  logic                 r_full, r_empty, r_ovf;
  logic [2:0]           r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par, r_tx, r_busy, r_led;

  logic                 w_pop, w_push, w_drop, w_baud_end;
  logic [DATA_BITS-1:0] w_head;
  logic [FIFO_AW:0]     w_count_nxt;

  // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
  assign w_pop      = (r_state == S_IDLE) && !r_empty;
  assign w_push     = send && (!r_full || w_pop);
  assign w_drop     = send && r_full && !w_pop;
  assign w_baud_end = (r_baud == BAUD_MAX);
  assign w_head     = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk_100) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk_100 or negedge clr_n) begin
    if (!clr_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_100 or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_led <= r_busy;
      if (r_state == S_IDLE) begin
        if (w_pop) begin
          r_shift <= w_head;
          r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
          r_state <= S_START;
          r_baud  <= '0;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else if (!w_baud_end) begin
        r_baud <= r_baud + 1'b1;
      end else begin
        // Bit boundary: tx is loaded here so it changes on the same edge as the state.
        r_baud <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          S_DATA: begin
            if (r_bit == BIT_MAX) begin
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
                r_stop  <= 1'b0;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
          S_PAR: begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_stop  <= 1'b0;
          end
          S_STOP: begin
            if (r_stop == STOP_MAX) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign led_tx   = r_led;
  assign full     = r_full;
  assign empty    = r_empty;
  assign level    = r_count;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 instance with a serial receiver model,
// plus 7E2 and 7O2 instances for parity and stop-bit framing.
module tb_uart_tx_fifo;
  logic clk_100 = 1'b0;
  logic clr_n   = 1'b1;
  always #5 clk_100 = ~clk_100;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] data_a = '0;
  logic       send_a = 1'b0, ovfclr_a = 1'b0;
  logic       tx_a, busy_a, led_a, full_a, empty_a, ovf_a;
  logic [4:0] level_a;

  logic [6:0] data_bc = '0;
  logic       send_b = 1'b0, send_c = 1'b0, ovfclr_bc = 1'b0;
  logic       tx_b, busy_b, led_b, full_b, empty_b, ovf_b;
  logic       tx_c, busy_c, led_c, full_c, empty_c, ovf_c;
  logic [4:0] level_b, level_c;

  uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(16), .PARITY(0), .STOP_BITS(1), .FIFO_AW(4)) u_a (
    .clk_100(clk_100), .clr_n(clr_n), .data_in(data_a), .send(send_a), .ovf_clr(ovfclr_a),
    .tx(tx_a), .busy(busy_a), .led_tx(led_a), .full(full_a), .empty(empty_a),
    .level(level_a), .overflow(ovf_a));

  uart_tx_fifo #(.DATA_BITS(7), .CLK_DIV(4), .PARITY(2), .STOP_BITS(2), .FIFO_AW(4)) u_b (
    .clk_100(clk_100), .clr_n(clr_n), .data_in(data_bc), .send(send_b), .ovf_clr(ovfclr_bc),
    .tx(tx_b), .busy(busy_b), .led_tx(led_b), .full(full_b), .empty(empty_b),
    .level(level_b), .overflow(ovf_b));

  uart_tx_fifo #(.DATA_BITS(7), .CLK_DIV(4), .PARITY(1), .STOP_BITS(2), .FIFO_AW(4)) u_c (
    .clk_100(clk_100), .clr_n(clr_n), .data_in(data_bc), .send(send_c), .ovf_clr(ovfclr_bc),
    .tx(tx_c), .busy(busy_c), .led_tx(led_c), .full(full_c), .empty(empty_c),
    .level(level_c), .overflow(ovf_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int s);
    case (s) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
  endfunction
  function automatic logic get_busy(input int s);
    case (s) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic get_empty(input int s);
    case (s) 0: return empty_a; 1: return empty_b; default: return empty_c; endcase
  endfunction
  function automatic logic get_led(input int s);
    case (s) 0: return led_a; 1: return led_b; default: return led_c; endcase
  endfunction

  task automatic push(input int s, input logic [7:0] d);
    @(negedge clk_100);
    case (s)
      0: begin data_a = d; send_a = 1'b1; end
      1: begin data_bc = d[6:0]; send_b = 1'b1; end
      default: begin data_bc = d[6:0]; send_c = 1'b1; end
    endcase
    @(negedge clk_100);
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
  endtask

  // Frame bits indexed from the start bit; sampled mid-bit, busy width counted.
  task automatic check_frame(input int s, input logic [10:0] e, input int nbits, input int div);
    int w = 0;
    int c = 0;
    while (get_tx(s) !== 1'b0 && w < 200) begin @(negedge clk_100); w++; end
    chk("start_seen", 32'(w < 200), 1);
    chk("empty_after_pop", get_empty(s), 1);
    chk("led_lag0", get_led(s), 0);
    while (get_busy(s) === 1'b1 && c < 1000) begin
      if (c == 1) chk("led_lag1", get_led(s), 1);
      if ((c % div) == div / 2 && c / div < nbits)
        chk($sformatf("dut%0d_bit%0d", s, c / div), get_tx(s), e[c / div]);
      c++;
      @(negedge clk_100);
    end
    chk("frame_len", c, nbits * div);
  endtask

  // Serial receiver for the 8N1 instance.
  logic [7:0] exp_q[$];
  int rx_cnt   = 0;
  int last_gap = 0;
  initial begin
    @(posedge clr_n);
    forever begin
      int cnt;
      logic [7:0] b;
      cnt = 0;
      @(negedge clk_100);
      while (tx_a !== 1'b0) begin cnt++; @(negedge clk_100); end
      repeat (7) @(negedge clk_100);
      chk("rx_start", tx_a, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk_100);
        b[i] = tx_a;
      end
      repeat (16) @(negedge clk_100);
      chk("rx_stop", tx_a, 1);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rx_extra: got %0h expected none", b);
      end else begin
        chk("rx_data", b, exp_q.pop_front());
      end
      last_gap = cnt - 8;
      rx_cnt++;
    end
  end

  task automatic wait_rx(input int target, input int budget);
    int k = 0;
    while (rx_cnt < target && k < budget) begin @(negedge clk_100); k++; end
    chk("rx_count", rx_cnt, target);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [10:0] frame;
    int         nbits;
    int         div;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int base, k, sent, bad;
    vecs[0] = '{0, 8'h23, 11'b00_1001000110, 10, 16};
    vecs[1] = '{0, 8'hA5, 11'b00_1101001010, 10, 16};
    vecs[2] = '{1, 8'h6F, 11'b11011011110, 11, 4};
    vecs[3] = '{2, 8'h6F, 11'b11111011110, 11, 4};
    vecs[4] = '{1, 8'h01, 11'b11100000010, 11, 4};
    vecs[5] = '{2, 8'h01, 11'b11000000010, 11, 4};

    #3 clr_n = 1'b0;
    #1;
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_led", led_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_level", level_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_empty_b", empty_b, 1);
    repeat (3) @(negedge clk_100);
    clr_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].sel == 0) exp_q.push_back(vecs[i].data);
      push(vecs[i].sel, vecs[i].data);
      check_frame(vecs[i].sel, vecs[i].frame, vecs[i].nbits, vecs[i].div);
    end
    wait_rx(2, 400);

    // Burst of 18 pushes while idle: head popped at once, 18th dropped.
    base = rx_cnt;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_100);
      if (i == 17) begin
        chk("t3_level16", level_a, 16);
        chk("t3_full", full_a, 1);
        chk("t3_no_ovf", ovf_a, 0);
      end
      data_a = 8'(8'h40 + i);
      send_a = 1'b1;
      if (i < 17) exp_q.push_back(data_a);
    end
    @(negedge clk_100);
    send_a = 1'b0;
    chk("t3_ovf_set", ovf_a, 1);
    chk("t3_level_hold", level_a, 16);
    ovfclr_a = 1'b1;
    @(negedge clk_100);
    ovfclr_a = 1'b0;
    chk("t3_ovf_clr", ovf_a, 0);

    // Hold send across the pop cycle with the FIFO full.
    k = 0;
    while (busy_a !== 1'b0 && k < 400) begin @(negedge clk_100); k++; end
    chk("t4_idle_found", busy_a, 0);
    data_a = 8'hC3;
    send_a = 1'b1;
    exp_q.push_back(8'hC3);
    @(negedge clk_100);
    chk("t4_level16", level_a, 16);
    chk("t4_no_ovf", ovf_a, 0);
    chk("t4_full", full_a, 1);
    @(negedge clk_100);
    chk("t4_ovf_after", ovf_a, 1);
    chk("t4_level_hold", level_a, 16);
    repeat (18) @(negedge clk_100);
    send_a = 1'b0;
    ovfclr_a = 1'b1;
    @(negedge clk_100);
    ovfclr_a = 1'b0;
    wait_rx(base + 1, 400);
    for (int i = 2; i <= 18; i++) begin
      wait_rx(base + i, 400);
      chk("t3_gap", last_gap, 1);
    end
    chk("t3_q_drained", exp_q.size(), 0);

    // Reset in the middle of data bit 3 of the 7E2 instance.
    @(negedge clk_100);
    data_bc = 7'h07; send_b = 1'b1;
    @(negedge clk_100);
    data_bc = 7'h10;
    @(negedge clk_100);
    send_b = 1'b0;
    repeat (17) @(negedge clk_100);
    chk("t5_bit3", tx_b, 0);
    #2 clr_n = 1'b0;
    #1;
    chk("t5_tx", tx_b, 1);
    chk("t5_busy", busy_b, 0);
    chk("t5_level", level_b, 0);
    chk("t5_empty", empty_b, 1);
    @(negedge clk_100);
    clr_n = 1'b1;
    @(negedge clk_100);
    chk("t5_level_rel", level_b, 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk_100);
      if (tx_b !== 1'b1 || busy_b !== 1'b0) bad++;
    end
    chk("t5_quiet", bad, 0);

    // 40 words through the 16-deep FIFO: pointers wrap twice.
    base = rx_cnt;
    sent = 0;
    k = 0;
    while (sent < 40 && k < 20000) begin
      @(negedge clk_100);
      if (!full_a) begin
        data_a = 8'(sent * 37 + 5);
        send_a = 1'b1;
        exp_q.push_back(data_a);
        sent++;
      end else begin
        send_a = 1'b0;
      end
      k++;
    end
    @(negedge clk_100);
    send_a = 1'b0;
    chk("t6_sent", sent, 40);
    wait_rx(base + 40, 40 * 200);
    chk("t6_q_drained", exp_q.size(), 0);
    chk("t6_no_ovf", ovf_a, 0);
    repeat (20) @(negedge clk_100);
    chk("t6_empty", empty_a, 1);
    chk("t6_level", level_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
